// File: rtl/pacote_controle.sv
// Shared definitions for the multicycle sequencer: state encodings, instruction
// classes, RV32I opcodes and ALUop codes.
package pacote_controle;

  typedef enum logic [2:0] {
    INICIO     = 3'd0,
    BUSCA      = 3'd1,
    DECODIFICA = 3'd2,
    EXECUTA    = 3'd3,
    MEMORIA    = 3'd4,
    ESCRITA    = 3'd5,
    ERRO       = 3'd6
  } estado_t;

  typedef enum logic [2:0] {
    CL_INVALIDA = 3'd0,
    CL_R        = 3'd1,
    CL_I        = 3'd2,
    CL_LOAD     = 3'd3,
    CL_STORE    = 3'd4,
    CL_BRANCH   = 3'd5
  } classe_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_SOMA    = 2'b00;
  localparam logic [1:0] ALUOP_COMPARA = 2'b01;
  localparam logic [1:0] ALUOP_FUNCAO  = 2'b10;

  function automatic classe_t decodifica_classe(input logic [6:0] op);
    case (op)
      OP_R:      return CL_R;
      OP_I:      return CL_I;
      OP_LOAD:   return CL_LOAD;
      OP_STORE:  return CL_STORE;
      OP_BRANCH: return CL_BRANCH;
      default:   return CL_INVALIDA;
    endcase
  endfunction

endpackage

// File: rtl/sequenciador_multiciclo_if.sv
// Shared memory port between the sequencer (master) and the memory (slave).
interface sequenciador_multiciclo_if;
  logic mem_req;
  logic mem_instr;
  logic mem_pronta;
  logic sinal_leitura;
  logic sinal_escrita;

  modport master (
    output mem_req, mem_instr, sinal_leitura, sinal_escrita,
    input  mem_pronta
  );

  modport slave (
    input  mem_req, mem_instr, sinal_leitura, sinal_escrita,
    output mem_pronta
  );
endinterface

// File: rtl/contador_espera.sv
// Memory wait-state counter: synchronous clear, saturating increment, and a flag
// raised when the count reaches LIMITE (never raised when LIMITE is 0).
module contador_espera #(
  parameter int LIMITE  = 15,
  parameter int LARGURA = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa_i,
  input  logic habilita_i,
  output logic limite_o
);

  logic [LARGURA-1:0] cont_q;
  logic [LARGURA-1:0] cont_d;

  // Count register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  // Next count: clear has priority, increment saturates at all-ones.
  always_comb begin
    cont_d = cont_q;
    if (limpa_i) begin
      cont_d = '0;
    end else if (habilita_i && (cont_q != {LARGURA{1'b1}})) begin
      cont_d = cont_q + {{(LARGURA-1){1'b0}}, 1'b1};
    end else begin
      cont_d = cont_q;
    end
  end

  assign limite_o = (LIMITE != 0) && (cont_q == LARGURA'(LIMITE));

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Multicycle control FSM for the RV32I-subset datapath: fetch, decode, execute,
// memory and writeback over a single shared memory port with wait states.
module sequenciador_multiciclo
  import pacote_controle::*;
#(
  parameter int ESPERA_MAX  = 15,
  parameter int LARG_ESPERA = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [6:0]                  opcode,
  input  logic                        resultado_desvio,
  sequenciador_multiciclo_if.master   bus,
  output logic                        ir_escrita,
  output logic                        pc_escrita,
  output logic                        sinal_mux,
  output logic                        reg_escrita,
  output logic                        ALUSrc,
  output logic                        MemToReg,
  output logic [1:0]                  ALUop,
  output logic                        instr_concluida,
  output logic                        erro,
  output logic [2:0]                  estado
);

  estado_t estado_q, estado_d;
  classe_t classe_q, classe_d;
  logic    req_mem, instr_mem, leitura, escrita_mem;
  logic    limite_espera;

  // The counter restarts on every state change, so BUSCA and MEMORIA always begin at zero.
  contador_espera #(.LIMITE(ESPERA_MAX), .LARGURA(LARG_ESPERA)) u_espera (
    .clock      (clock),
    .reset      (reset),
    .limpa_i    (estado_d != estado_q),
    .habilita_i (req_mem && !bus.mem_pronta),
    .limite_o   (limite_espera)
  );

  // State and latched instruction class, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= INICIO;
      classe_q <= CL_INVALIDA;
    end else begin
      estado_q <= estado_d;
      classe_q <= classe_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    estado_d        = estado_q;
    classe_d        = classe_q;
    req_mem         = 1'b0;
    instr_mem       = 1'b0;
    leitura         = 1'b0;
    escrita_mem     = 1'b0;
    ir_escrita      = 1'b0;
    pc_escrita      = 1'b0;
    sinal_mux       = 1'b0;
    reg_escrita     = 1'b0;
    ALUSrc          = 1'b0;
    MemToReg        = 1'b0;
    ALUop           = ALUOP_SOMA;
    instr_concluida = 1'b0;
    erro            = 1'b0;
    case (estado_q)
      INICIO: estado_d = BUSCA;
      BUSCA: begin
        req_mem   = 1'b1;
        instr_mem = 1'b1;
        if (bus.mem_pronta) begin
          ir_escrita = 1'b1;
          pc_escrita = 1'b1;
          estado_d   = DECODIFICA;
        end else if (limite_espera) begin
          estado_d = ERRO;
        end else begin
          estado_d = BUSCA;
        end
      end
      DECODIFICA: begin
        classe_d = decodifica_classe(opcode);
        estado_d = (classe_d == CL_INVALIDA) ? ERRO : EXECUTA;
      end
      EXECUTA: begin
        case (classe_q)
          CL_R: begin
            ALUop    = ALUOP_FUNCAO;
            estado_d = ESCRITA;
          end
          CL_I: begin
            ALUSrc   = 1'b1;
            ALUop    = ALUOP_FUNCAO;
            estado_d = ESCRITA;
          end
          CL_LOAD, CL_STORE: begin
            ALUSrc   = 1'b1;
            estado_d = MEMORIA;
          end
          CL_BRANCH: begin
            // A taken branch overwrites the PC+4 already written during fetch.
            ALUop           = ALUOP_COMPARA;
            pc_escrita      = resultado_desvio;
            sinal_mux       = resultado_desvio;
            instr_concluida = 1'b1;
            estado_d        = BUSCA;
          end
          default: estado_d = ERRO;
        endcase
      end
      MEMORIA: begin
        req_mem     = 1'b1;
        leitura     = (classe_q == CL_LOAD);
        escrita_mem = (classe_q == CL_STORE);
        if (bus.mem_pronta) begin
          instr_concluida = (classe_q != CL_LOAD);
          estado_d        = (classe_q == CL_LOAD) ? ESCRITA : BUSCA;
        end else if (limite_espera) begin
          estado_d = ERRO;
        end else begin
          estado_d = MEMORIA;
        end
      end
      ESCRITA: begin
        reg_escrita     = 1'b1;
        MemToReg        = (classe_q == CL_LOAD);
        instr_concluida = 1'b1;
        estado_d        = BUSCA;
      end
      ERRO: erro = 1'b1;
      default: begin
        erro     = 1'b1;
        estado_d = ERRO;
      end
    endcase
  end

  assign bus.mem_req       = req_mem;
  assign bus.mem_instr     = instr_mem;
  assign bus.sinal_leitura = leitura;
  assign bus.sinal_escrita = escrita_mem;
  assign estado            = estado_q;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Scoreboard bench for sequenciador_multiciclo: directed cycles push expected
// output vectors, a negedge monitor pops and compares them.
module tb_sequenciador_multiciclo;

  typedef struct {
    string       nome;
    logic [16:0] valor;
  } esperado_t;

  localparam logic [6:0] TB_R      = 7'b0110011;
  localparam logic [6:0] TB_I      = 7'b0010011;
  localparam logic [6:0] TB_LOAD   = 7'b0000011;
  localparam logic [6:0] TB_STORE  = 7'b0100011;
  localparam logic [6:0] TB_BRANCH = 7'b1100011;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       resultado_desvio;
  logic       ir_escrita, pc_escrita, sinal_mux, reg_escrita;
  logic       ALUSrc, MemToReg, instr_concluida, erro;
  logic [1:0] ALUop;
  logic [2:0] estado;

  int errors = 0;
  int checks = 0;
  esperado_t sb_q[$];

  sequenciador_multiciclo_if mem_if ();

  sequenciador_multiciclo #(.ESPERA_MAX(15), .LARG_ESPERA(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .opcode           (opcode),
    .resultado_desvio (resultado_desvio),
    .bus              (mem_if),
    .ir_escrita       (ir_escrita),
    .pc_escrita       (pc_escrita),
    .sinal_mux        (sinal_mux),
    .reg_escrita      (reg_escrita),
    .ALUSrc           (ALUSrc),
    .MemToReg         (MemToReg),
    .ALUop            (ALUop),
    .instr_concluida  (instr_concluida),
    .erro             (erro),
    .estado           (estado)
  );

  always #5 clock = ~clock;

  // Vector layout: estado, req, instr, leit, escr, ir, pc, mux, reg, src, m2r, aluop, concl, erro.
  function automatic logic [16:0] ev(input logic [2:0] st, input logic req, input logic ins,
                                     input logic le, input logic es, input logic ir, input logic pc,
                                     input logic mx, input logic rg, input logic src, input logic m2r,
                                     input logic [1:0] aop, input logic co, input logic er);
    return {st, req, ins, le, es, ir, pc, mx, rg, src, m2r, aop, co, er};
  endfunction

  function automatic logic [16:0] f_inicio();
    return ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] f_busca(input logic p);
    return ev(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, p, p, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] f_dec();
    return ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] f_exec(input logic src, input logic [1:0] aop, input logic pc,
                                         input logic mx, input logic co);
    return ev(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pc, mx, 1'b0, src, 1'b0, aop, co, 1'b0);
  endfunction
  function automatic logic [16:0] f_mem(input logic le, input logic es, input logic co);
    return ev(3'd4, 1'b1, 1'b0, le, es, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, co, 1'b0);
  endfunction
  function automatic logic [16:0] f_escr(input logic m2r);
    return ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, m2r, 2'b00, 1'b1, 1'b0);
  endfunction
  function automatic logic [16:0] f_erro();
    return ev(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
  endfunction

  task automatic ciclo(input logic [16:0] esp, input string nome);
    esperado_t e;
    e.nome  = nome;
    e.valor = esp;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares one expected vector per checked cycle, away from the active edge.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      esperado_t e;
      logic [16:0] atual;
      e = sb_q.pop_front();
      atual = {estado, mem_if.mem_req, mem_if.mem_instr, mem_if.sinal_leitura,
               mem_if.sinal_escrita, ir_escrita, pc_escrita, sinal_mux, reg_escrita,
               ALUSrc, MemToReg, ALUop, instr_concluida, erro};
      checks++;
      if (atual !== e.valor) begin
        errors++;
        $display("FAIL %s: got %05h expected %05h", e.nome, atual, e.valor);
      end
    end
  end

  initial begin
    reset = 1'b0;
    opcode = 7'd0;
    resultado_desvio = 1'b0;
    mem_if.mem_pronta = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) ciclo(f_inicio(), "reset_hold");
    reset = 1'b1;
    ciclo(f_inicio(), "reset_release");
    ciclo(f_busca(1'b0), "first_fetch_req");

    // add, zero wait states: 4 cycles
    mem_if.mem_pronta = 1'b1;
    opcode = TB_R;
    ciclo(f_busca(1'b1), "add_busca");
    ciclo(f_dec(), "add_dec");
    ciclo(f_exec(1'b0, 2'b10, 1'b0, 1'b0, 1'b0), "add_exec");
    ciclo(f_escr(1'b0), "add_escrita");

    // lw, 3 data wait states: 8 cycles
    opcode = TB_LOAD;
    ciclo(f_busca(1'b1), "lw_busca");
    ciclo(f_dec(), "lw_dec");
    ciclo(f_exec(1'b1, 2'b00, 1'b0, 1'b0, 1'b0), "lw_exec");
    mem_if.mem_pronta = 1'b0;
    for (int i = 0; i < 3; i++) ciclo(f_mem(1'b1, 1'b0, 1'b0), "lw_mem_wait");
    mem_if.mem_pronta = 1'b1;
    ciclo(f_mem(1'b1, 1'b0, 1'b0), "lw_mem_done");
    ciclo(f_escr(1'b1), "lw_escrita");

    // beq taken and not taken: 3 cycles each
    opcode = TB_BRANCH;
    resultado_desvio = 1'b1;
    ciclo(f_busca(1'b1), "beq_t_busca");
    ciclo(f_dec(), "beq_t_dec");
    ciclo(f_exec(1'b0, 2'b01, 1'b1, 1'b1, 1'b1), "beq_t_exec");
    resultado_desvio = 1'b0;
    ciclo(f_busca(1'b1), "beq_n_busca");
    ciclo(f_dec(), "beq_n_dec");
    ciclo(f_exec(1'b0, 2'b01, 1'b0, 1'b0, 1'b1), "beq_n_exec");

    // addi
    opcode = TB_I;
    ciclo(f_busca(1'b1), "addi_busca");
    ciclo(f_dec(), "addi_dec");
    ciclo(f_exec(1'b1, 2'b10, 1'b0, 1'b0, 1'b0), "addi_exec");
    ciclo(f_escr(1'b0), "addi_escrita");

    // sw with one data wait state
    opcode = TB_STORE;
    ciclo(f_busca(1'b1), "sw_busca");
    ciclo(f_dec(), "sw_dec");
    ciclo(f_exec(1'b1, 2'b00, 1'b0, 1'b0, 1'b0), "sw_exec");
    mem_if.mem_pronta = 1'b0;
    ciclo(f_mem(1'b0, 1'b1, 1'b0), "sw_mem_wait");
    mem_if.mem_pronta = 1'b1;
    ciclo(f_mem(1'b0, 1'b1, 1'b1), "sw_mem_done");

    // Fetch completes on the very cycle the wait limit is reached
    opcode = TB_R;
    mem_if.mem_pronta = 1'b0;
    for (int i = 0; i < 15; i++) ciclo(f_busca(1'b0), "limit_fetch_wait");
    mem_if.mem_pronta = 1'b1;
    ciclo(f_busca(1'b1), "limit_fetch_wins");
    ciclo(f_dec(), "limit_dec");
    ciclo(f_exec(1'b0, 2'b10, 1'b0, 1'b0, 1'b0), "limit_exec");
    ciclo(f_escr(1'b0), "limit_escrita");

    // Reset during sw MEMORIA aborts the store
    opcode = TB_STORE;
    ciclo(f_busca(1'b1), "swr_busca");
    ciclo(f_dec(), "swr_dec");
    ciclo(f_exec(1'b1, 2'b00, 1'b0, 1'b0, 1'b0), "swr_exec");
    mem_if.mem_pronta = 1'b0;
    ciclo(f_mem(1'b0, 1'b1, 1'b0), "swr_mem");
    reset = 1'b0;
    ciclo(f_mem(1'b0, 1'b1, 1'b0), "swr_mem_reset_cycle");
    ciclo(f_inicio(), "swr_aborted");
    reset = 1'b1;
    ciclo(f_inicio(), "swr_release");

    // Fetch timeout: 16 BUSCA cycles then sticky ERRO
    for (int i = 0; i < 16; i++) ciclo(f_busca(1'b0), "timeout_busca");
    ciclo(f_erro(), "timeout_erro");
    mem_if.mem_pronta = 1'b1;
    ciclo(f_erro(), "timeout_sticky");
    ciclo(f_erro(), "timeout_sticky2");

    // Only reset leaves ERRO; then an illegal opcode
    reset = 1'b0;
    ciclo(f_erro(), "erro_reset_cycle");
    reset = 1'b1;
    ciclo(f_inicio(), "erro_cleared");
    opcode = 7'b1111111;
    ciclo(f_busca(1'b1), "ilegal_busca");
    ciclo(f_dec(), "ilegal_dec");
    ciclo(f_erro(), "ilegal_erro");
    ciclo(f_erro(), "ilegal_sticky");

    @(posedge clock);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
